wind_decoder: RTL and testbench

- Receive side of the runway wind-indicator light protocol.
- Samples the 3-bit light pattern driven by the wind indicator FSM and recovers the wind-direction code from successive pattern pairs.
- Confirms the code over CONFIRM consistent transitions before publishing it.
- Flags and counts illegal patterns; used in self-check harnesses and on the board to drive direction LEDs from observed lights.

---
 rtl/wind_pkg.sv | 23 ++
 rtl/wind_pair_decode.sv | 44 ++++
 rtl/wind_decoder.sv | 99 +++++++++
 tb/tb_wind_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wind_pkg.sv
// rtl/wind_pkg.sv - light patterns, direction codes and legality check for the wind-light protocol
package wind_pkg;

    typedef enum logic [2:0] {
        P101 = 3'b101,
        P010 = 3'b010,
        P100 = 3'b100,
        P001 = 3'b001
    } pattern_t;

    typedef enum logic [1:0] {
        DIR_CALM = 2'b00,
        DIR_RL   = 2'b01,
        DIR_LR   = 2'b10,
        DIR_HOLD = 2'b11
    } dir_t;

    function automatic logic is_legal(input logic [2:0] pattern);
        return (pattern == P101) || (pattern == P010) ||
               (pattern == P100) || (pattern == P001);
    endfunction

endpackage

// File: rtl/wind_pair_decode.sv
// rtl/wind_pair_decode.sv - combinational (prev, cur) light pair to direction code decode
module wind_pair_decode
    import wind_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] cur,
    output logic [1:0] code,
    output logic       legal
);

    always_comb begin
        code  = DIR_HOLD;
        legal = is_legal(prev) && is_legal(cur);
        // A pattern repeated unchanged always decodes as hold, hence the HOLD defaults.
        case (prev)
            P101: case (cur)
                P010:    code = DIR_CALM;
                P001:    code = DIR_RL;
                P100:    code = DIR_LR;
                default: code = DIR_HOLD;
            endcase
            P010: case (cur)
                P101:    code = DIR_CALM;
                P100:    code = DIR_RL;
                P001:    code = DIR_LR;
                default: code = DIR_HOLD;
            endcase
            P100: case (cur)
                P101:    code = DIR_CALM;
                P001:    code = DIR_RL;
                P010:    code = DIR_LR;
                default: code = DIR_HOLD;
            endcase
            P001: case (cur)
                P101:    code = DIR_CALM;
                P010:    code = DIR_RL;
                P100:    code = DIR_LR;
                default: code = DIR_HOLD;
            endcase
            default: code = DIR_HOLD;
        endcase
    end

endmodule

// File: rtl/wind_decoder.sv
// rtl/wind_decoder.sv - recovers and confirms the wind direction code from sampled light patterns
module wind_decoder
    import wind_pkg::*;
#(
    parameter int CONFIRM   = 2,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [2:0]           lights,
    output logic [1:0]           dir,
    output logic                 dir_valid,
    output logic                 change,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;
    localparam logic [2:0] CONF    = 3'(CONFIRM);

    logic [1:0] state;
    logic [2:0] prev;
    logic [1:0] cand;
    logic [2:0] run;

    logic [1:0] code;
    logic       pair_legal;
    logic [2:0] run_next;
    logic       load;

    // prev only ever holds a legal pattern, so pair legality reduces to legality of lights.
    wind_pair_decode u_pair (
        .prev  (prev),
        .cur   (lights),
        .code  (code),
        .legal (pair_legal)
    );

    always_comb begin
        if (code == cand && run != 3'd0) begin
            run_next = (run == CONF) ? CONF : run + 3'd1;
        end else begin
            run_next = 3'd1;
        end
        load = (run_next == CONF) && (!dir_valid || code != dir);
    end

    always_ff @(posedge clk) begin
        change <= 1'b0;
        err    <= 1'b0;
        if (reset) begin
            state     <= S_EMPTY;
            prev      <= P101;
            cand      <= DIR_CALM;
            run       <= 3'd0;
            dir       <= DIR_CALM;
            dir_valid <= 1'b0;
            err_count <= '0;
        end else if (en) begin
            if (!pair_legal) begin
                err <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
            case (state)
                S_TRACK: begin
                    if (pair_legal) begin
                        prev <= lights;
                        run  <= run_next;
                        if (run_next == 3'd1) begin
                            cand <= code;
                        end
                        if (load) begin
                            dir       <= code;
                            dir_valid <= 1'b1;
                            change    <= 1'b1;
                        end
                    end else begin
                        dir_valid <= 1'b0;
                        run       <= 3'd0;
                        state     <= S_FAULT;
                    end
                end
                S_EMPTY, S_FAULT: begin
                    if (pair_legal) begin
                        prev  <= lights;
                        state <= S_TRACK;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_wind_decoder.sv
// tb/tb_wind_decoder.sv - directed and randomized check of wind_decoder against a history-based model
module tb_wind_decoder;

    localparam int CONFIRM   = 2;
    localparam int ERR_CNT_W = 4;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 en = 1'b0;
    logic [2:0]           lights = 3'b000;
    logic [1:0]           dir;
    logic                 dir_valid;
    logic                 change;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    wind_decoder #(.CONFIRM(CONFIRM), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .lights    (lights),
        .dir       (dir),
        .dir_valid (dir_valid),
        .change    (change),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Protocol table: pat[i] is a legal pattern; nxt[i][c] is the pattern following pat[i] for code c.
    logic [2:0] pat [4];
    logic [2:0] nxt [4][4];

    int         m_have_ref;
    logic [2:0] m_prev;
    int         hist[$];
    int         m_dir, m_valid, m_change, m_err, m_cnt;
    int         n_change;

    function automatic int pat_idx(input logic [2:0] p);
        for (int i = 0; i < 4; i++) if (pat[i] == p) return i;
        return -1;
    endfunction

    function automatic int pair_code(input logic [2:0] p, input logic [2:0] c);
        int pi;
        pi = pat_idx(p);
        for (int k = 0; k < 4; k++) if (nxt[pi][k] == c) return k;
        return -1;
    endfunction

    function automatic bit confirmed();
        if (hist.size() < CONFIRM) return 0;
        for (int k = 1; k <= CONFIRM; k++)
            if (hist[hist.size()-k] != hist[hist.size()-1]) return 0;
        return 1;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [2:0] l);
        int code;
        m_change = 0;
        m_err    = 0;
        if (r) begin
            m_have_ref = 0; m_prev = 3'b101; hist.delete();
            m_dir = 0; m_valid = 0; m_cnt = 0;
        end else if (e) begin
            if (pat_idx(l) < 0) begin
                m_err = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_valid = 0;
                m_have_ref = 0;
                hist.delete();
            end else if (m_have_ref == 0) begin
                m_prev = l;
                m_have_ref = 1;
            end else begin
                code = pair_code(m_prev, l);
                m_prev = l;
                hist.push_back(code);
                if (hist.size() > 8) void'(hist.pop_front());
                if (confirmed() && (m_valid == 0 || code != m_dir)) begin
                    m_dir = code; m_valid = 1; m_change = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [2:0] l);
        reset = r; en = e; lights = l;
        @(posedge clk);
        model_step(r, e, l);
        @(negedge clk);
        n_change += int'(change);
        chk("dir", int'(dir), m_dir);
        chk("dir_valid", int'(dir_valid), m_valid);
        chk("change", int'(change), m_change);
        chk("err", int'(err), m_err);
        chk("err_count", int'(err_count), m_cnt);
    endtask

    task automatic seq(input logic [2:0] s [$]);
        foreach (s[i]) cycle(1'b0, 1'b1, s[i]);
    endtask

    initial begin
        logic [2:0] q [$];
        logic [2:0] last;
        int cur_code, roll;

        pat[0] = 3'b101; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b001;
        nxt[0][0] = 3'b010; nxt[0][1] = 3'b001; nxt[0][2] = 3'b100; nxt[0][3] = 3'b101;
        nxt[1][0] = 3'b101; nxt[1][1] = 3'b100; nxt[1][2] = 3'b001; nxt[1][3] = 3'b010;
        nxt[2][0] = 3'b101; nxt[2][1] = 3'b001; nxt[2][2] = 3'b010; nxt[2][3] = 3'b100;
        nxt[3][0] = 3'b101; nxt[3][1] = 3'b010; nxt[3][2] = 3'b100; nxt[3][3] = 3'b001;
        m_have_ref = 0; m_prev = 3'b101; m_dir = 0; m_valid = 0; m_cnt = 0;
        m_change = 0; m_err = 0; n_change = 0;

        @(negedge clk);
        cycle(1'b1, 1'b1, 3'b000);
        cycle(1'b1, 1'b0, 3'b101);

        // Calm
        n_change = 0;
        q = '{3'b101, 3'b010, 3'b101, 3'b010};
        seq(q);
        chk("calm_dir", int'(dir), 0);
        chk("calm_valid", int'(dir_valid), 1);
        chk("calm_pulses", n_change, 1);

        // Left-to-right, then right-to-left, then hold
        cycle(1'b1, 1'b1, 3'b000);
        n_change = 0;
        q = '{3'b101, 3'b100, 3'b010, 3'b001, 3'b100};
        seq(q);
        chk("lr_dir", int'(dir), 2);
        chk("lr_pulses", n_change, 1);
        q = '{3'b001, 3'b010};
        seq(q);
        chk("rl_dir", int'(dir), 1);
        q = '{3'b100, 3'b010, 3'b001, 3'b101, 3'b100, 3'b001, 3'b001, 3'b001};
        seq(q);
        chk("hold_dir", int'(dir), 3);

        // Fault and recovery
        q = '{3'b111, 3'b101, 3'b010, 3'b101};
        seq(q);
        chk("fault_cnt", int'(err_count), 1);
        chk("recover_valid", int'(dir_valid), 1);

        // Gating
        n_change = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'(i));
        chk("gated_pulses", n_change, 0);

        // Saturation then reset while tracking
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 3'b000);
        chk("sat_cnt", int'(err_count), CNT_MAX);
        q = '{3'b101, 3'b010, 3'b101};
        seq(q);
        cycle(1'b1, 1'b1, 3'b010);
        chk("rst_cnt", int'(err_count), 0);
        chk("rst_valid", int'(dir_valid), 0);

        // Randomized walk with sticky codes, faults, gating and occasional reset
        last = 3'b101;
        cur_code = 0;
        for (int i = 0; i < 600; i++) begin
            roll = int'($urandom_range(0, 99));
            if (roll < 4) begin
                q = '{3'b000, 3'b011, 3'b110, 3'b111};
                cycle(1'b0, 1'b1, q[$urandom_range(0, 3)]);
            end else if (roll < 10) begin
                cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            end else if (roll < 11) begin
                cycle(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            end else begin
                if ($urandom_range(0, 3) == 0) cur_code = int'($urandom_range(0, 3));
                last = nxt[pat_idx(last)][cur_code];
                cycle(1'b0, 1'b1, last);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
